// File: rtl/lsu_bus_pkg.sv
// lsu_bus_pkg: shared types, address-map constants and data-path helpers
// for the load/store bus controller.
//   size_e   : request access size (byte / half / word / illegal)
//   state_e  : controller sequencing states
//   region_e : result of address decode
//   decode() : region + alignment / size legality check
//   merge()  : insert store data into a read word (sub-word RMW)
//   extract(): pull a load lane down to bit 0 and extend it
package lsu_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_MEM_CAP,
    ST_MEM_WR,
    ST_OP_ACC,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    RG_DMEM,
    RG_OP,
    RG_ERR
  } region_e;

  localparam logic [15:0] DMEM_BASE = 16'h2000;
  localparam logic [15:0] DMEM_MASK = 16'hE000;
  localparam logic [15:0] OP_BASE   = 16'h7000;
  localparam logic [15:0] OP_MASK   = 16'hFFC0;

  // Misaligned or illegal-size accesses are folded into RG_ERR so the
  // controller only has one error path.
  function automatic region_e decode(input logic [15:0] addr, input size_e size);
    region_e r;
    if (size == SZ_BAD)                              r = RG_ERR;
    else if (size == SZ_HALF && addr[0])             r = RG_ERR;
    else if (size == SZ_WORD && addr[1:0] != 2'b00)  r = RG_ERR;
    else if ((addr & DMEM_MASK) == DMEM_BASE)        r = RG_DMEM;
    else if ((addr & OP_MASK) == OP_BASE)            r = RG_OP;
    else                                             r = RG_ERR;
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_word,
                                        input logic [31:0] wdata,
                                        input size_e       size,
                                        input logic [1:0]  lane);
    logic [31:0] r;
    r = old_word;
    case (size)
      SZ_BYTE: r[{lane, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input size_e       size,
                                          input logic [1:0]  lane,
                                          input logic        is_unsigned);
    logic [31:0] sh;
    logic [31:0] r;
    case (size)
      SZ_BYTE: begin
        sh = word >> {lane, 3'b000};
        r  = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
      end
      SZ_HALF: begin
        sh = word >> {lane[1], 4'b0000};
        r  = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
      end
      default: begin
        sh = word;
        r  = sh;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_rr_arb2.sv
// lsu_rr_arb2: 2-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid[1:0] : requests
//   en         : arbitration allowed this cycle
//   grant[1:0] : one-hot grant (zero when disabled or idle)
//   ptr        : preferred requester; moves to the loser after each grant
module lsu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (!ptr) grant = valid[0] ? 2'b01 : (valid[1] ? 2'b10 : 2'b00);
      else      grant = valid[1] ? 2'b10 : (valid[0] ? 2'b01 : 2'b00);
    end
  end

  // Granting 0 makes 1 preferred next and vice versa: ptr <= grant[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (|grant) ptr <= grant[0];
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store bus sequencer. Arbitrates two requesters,
// decodes DMEM / output-peripheral / unmapped, drives a 1-cycle-latency
// data memory or a combinational-read peripheral bank, and performs
// sub-word stores as read-modify-write.
//   i_req_*  : per-requester request channel, o_req_ready one-hot accept
//   o_rsp_*  : one-cycle response pulse to the owning requester
//   o_mem_*  / i_mem_rdata : synchronous data memory port
//   o_op_*   / i_op_rdata  : peripheral register bank port
module lsu_bus_ctrl
  import lsu_bus_pkg::*;
#(
  parameter int DMEM_AW = 11,
  parameter int OP_AW   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_req_valid,
  output logic [1:0]            o_req_ready,
  input  logic [1:0][15:0]      i_req_addr,
  input  logic [1:0]            i_req_we,
  input  logic [1:0][1:0]       i_req_size,
  input  logic [1:0]            i_req_unsigned,
  input  logic [1:0][31:0]      i_req_wdata,
  output logic [1:0]            o_rsp_valid,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [DMEM_AW-1:0]    o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_op_we,
  output logic [OP_AW-1:0]      o_op_addr,
  output logic [31:0]           o_op_wdata,
  input  logic [31:0]           i_op_rdata
);

  state_e                state_reg, state_next;
  logic                  id_reg;
  logic [DMEM_AW+1:0]    addr_reg;
  logic                  we_reg;
  size_e                 size_reg;
  logic                  uns_reg;
  logic [31:0]           wdata_reg;
  logic [31:0]           rd_reg;
  logic                  err_reg;

  logic [1:0]            grant;
  logic                  arb_ptr;
  logic                  sel;
  logic                  accept;
  size_e                 size_in;
  region_e               region_in;

  // Gating with reset keeps ready low while reset is held.
  lsu_rr_arb2 u_arb (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .valid (i_req_valid),
    .en    (state_reg == ST_IDLE && i_rst_n),
    .grant (grant),
    .ptr   (arb_ptr)
  );

  assign sel       = grant[1];
  assign accept    = |grant;
  assign size_in   = size_e'(i_req_size[sel]);
  // Decode on the payload being latched so an error can respond at T+1.
  assign region_in = decode(i_req_addr[sel], size_in);
  assign o_req_ready = grant;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (region_in == RG_ERR)                        state_next = ST_RESP;
          else if (region_in == RG_OP)                    state_next = ST_OP_ACC;
          else if (i_req_we[sel] && size_in == SZ_WORD)   state_next = ST_MEM_WR;
          else                                            state_next = ST_MEM_RD;
        end
      end
      ST_MEM_RD:  state_next = ST_MEM_CAP;
      ST_MEM_CAP: state_next = we_reg ? ST_MEM_WR : ST_RESP;
      ST_MEM_WR:  state_next = ST_RESP;
      ST_OP_ACC:  state_next = ST_RESP;
      ST_RESP:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      id_reg    <= 1'b0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      size_reg  <= SZ_BYTE;
      uns_reg   <= 1'b0;
      wdata_reg <= '0;
      rd_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        id_reg    <= sel;
        addr_reg  <= i_req_addr[sel][DMEM_AW+1:0];
        we_reg    <= i_req_we[sel];
        size_reg  <= size_in;
        uns_reg   <= i_req_unsigned[sel];
        wdata_reg <= i_req_wdata[sel];
        err_reg   <= (region_in == RG_ERR);
      end
      if (state_reg == ST_MEM_CAP)             rd_reg <= i_mem_rdata;
      if (state_reg == ST_OP_ACC && !we_reg)   rd_reg <= i_op_rdata;
    end
  end

  // Strobes depend only on state, so an asynchronous reset drops them at once
  // and an interrupted RMW never reaches MEM_WR.
  always_comb begin
    o_mem_en    = (state_reg == ST_MEM_RD) || (state_reg == ST_MEM_WR);
    o_mem_we    = (state_reg == ST_MEM_WR);
    o_mem_addr  = addr_reg[DMEM_AW+1:2];
    o_mem_wdata = '0;
    if (state_reg == ST_MEM_WR)
      o_mem_wdata = merge(rd_reg, wdata_reg, size_reg, addr_reg[1:0]);
    o_op_we    = (state_reg == ST_OP_ACC) && we_reg;
    o_op_addr  = addr_reg[OP_AW+1:2];
    o_op_wdata = '0;
    if (o_op_we)
      o_op_wdata = merge(i_op_rdata, wdata_reg, size_reg, addr_reg[1:0]);
    o_rsp_valid = 2'b00;
    o_rsp_err   = 1'b0;
    o_rsp_rdata = '0;
    if (state_reg == ST_RESP) begin
      o_rsp_valid = id_reg ? 2'b10 : 2'b01;
      o_rsp_err   = err_reg;
      if (!err_reg && !we_reg)
        o_rsp_rdata = extract(rd_reg, size_reg, addr_reg[1:0], uns_reg);
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed-vector bench for lsu_bus_ctrl. A behavioural
// 1-cycle-latency memory and a settable peripheral read value feed the DUT;
// every response, latency and strobe count is compared to hand-computed values.
module tb_lsu_bus_ctrl;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][15:0] req_addr;
  logic [1:0]       req_we;
  logic [1:0][1:0]  req_size;
  logic [1:0]       req_uns;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             mem_en, mem_we;
  logic [10:0]      mem_addr;
  logic [31:0]      mem_wdata, mem_q;
  logic             op_we;
  logic [3:0]       op_addr;
  logic [31:0]      op_wdata, op_val;

  int n_chk = 0;
  int n_bad = 0;
  int ptr_model = 0;

  logic [31:0] mem [0:2047];

  lsu_bus_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_addr     (req_addr),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_uns),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_mem_en       (mem_en),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_q),
    .o_op_we        (op_we),
    .o_op_addr      (op_addr),
    .o_op_wdata     (op_wdata),
    .i_op_rdata     (op_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_q <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request from requester id; checks acceptance, response latency,
  // response contents and the strobes seen on the way.
  task automatic txn(input int id, input logic [15:0] addr, input logic we,
                     input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                     input int e_lat, input logic e_err, input logic [31:0] e_rdata,
                     input int e_rd, input int e_wr, input int e_opwe,
                     input logic [31:0] e_wd, input logic [10:0] e_ma);
    int cyc;
    int lat;
    int n_rd, n_wr, n_opwe;
    logic [31:0] wd, rdata;
    logic [10:0] ma;
    logic [1:0]  rv;
    logic        err;
    n_rd = 0; n_wr = 0; n_opwe = 0; wd = '0; ma = '0; lat = 0;
    rv = '0; err = 1'b0; rdata = '0;
    @(posedge clk); #1;
    req_addr[id] = addr; req_we[id] = we; req_size[id] = size;
    req_uns[id] = uns; req_wdata[id] = wdata; req_valid[id] = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!req_ready[id] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept", {31'd0, req_ready[id]}, 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    req_addr[id] = 16'hFFFF;
    req_wdata[id] = 32'h0BAD0BAD;
    ptr_model = 1 - id;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_en && !mem_we) begin n_rd++; ma = mem_addr; end
      if (mem_we) begin n_wr++; wd = mem_wdata; ma = mem_addr; end
      if (op_we) begin n_opwe++; wd = op_wdata; end
      if (rsp_valid != 2'b00) begin
        lat = k; rv = rsp_valid; err = rsp_err; rdata = rsp_rdata;
        break;
      end
    end
    chk("latency", lat, e_lat);
    chk("rsp_valid", {30'd0, rv}, (id == 1) ? 32'd2 : 32'd1);
    chk("rsp_err", {31'd0, err}, {31'd0, e_err});
    chk("rsp_rdata", rdata, e_rdata);
    chk("mem_rd_cnt", n_rd, e_rd);
    chk("mem_wr_cnt", n_wr, e_wr);
    chk("op_we_cnt", n_opwe, e_opwe);
    if (e_wr + e_opwe > 0) chk("wdata", wd, e_wd);
    if (e_rd + e_wr > 0)   chk("mem_addr", {21'd0, ma}, {21'd0, e_ma});
    $display("txn id=%0d addr=%h we=%0d size=%0d uns=%0d lat=%0d err=%0d rdata=%h",
             id, addr, we, size, uns, lat, err, rdata);
  endtask

  initial begin
    int cnt [2];
    int exp_id, got_id, cyc, k, n_bad_strobe;
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; req_we = '0; req_size = '0;
    req_uns = '0; req_wdata = '0; op_val = 32'h0;
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_strobes", {29'd0, mem_en, mem_we, op_we}, 32'd0);
    chk("rst_addr", {17'd0, mem_addr, op_addr}, 32'd0);
    chk("rst_wdata", mem_wdata | op_wdata, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    //   id addr     we size  uns wdata         lat err rdata        rd wr op  wd            ma
    txn(0, 16'h2004, 1, 2'b10, 0, 32'hDEADBEEF, 2, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF, 11'd1);
    txn(0, 16'h2004, 0, 2'b10, 0, 32'h0,        3, 0, 32'hDEADBEEF, 1, 0, 0, 32'h0,        11'd1);
    txn(1, 16'h2004, 1, 2'b10, 0, 32'h11223344, 2, 0, 32'h0,        0, 1, 0, 32'h11223344, 11'd1);
    txn(0, 16'h2006, 1, 2'b00, 0, 32'h00000055, 4, 0, 32'h0,        1, 1, 0, 32'h11553344, 11'd1);
    txn(1, 16'h2004, 0, 2'b10, 0, 32'h0,        3, 0, 32'h11553344, 1, 0, 0, 32'h0,        11'd1);
    txn(0, 16'h2006, 1, 2'b01, 0, 32'h1234CAFE, 4, 0, 32'h0,        1, 1, 0, 32'hCAFE3344, 11'd1);
    txn(1, 16'h2006, 0, 2'b01, 0, 32'h0,        3, 0, 32'hFFFFCAFE, 1, 0, 0, 32'h0,        11'd1);
    txn(0, 16'h2006, 0, 2'b01, 1, 32'h0,        3, 0, 32'h0000CAFE, 1, 0, 0, 32'h0,        11'd1);
    txn(0, 16'h2005, 0, 2'b00, 0, 32'h0,        3, 0, 32'h00000033, 1, 0, 0, 32'h0,        11'd1);
    txn(1, 16'h2007, 0, 2'b00, 0, 32'h0,        3, 0, 32'hFFFFFFCA, 1, 0, 0, 32'h0,        11'd1);
    op_val = 32'h80000000;
    txn(0, 16'h7003, 0, 2'b00, 0, 32'h0,        2, 0, 32'hFFFFFF80, 0, 0, 0, 32'h0,        11'd0);
    txn(1, 16'h7003, 0, 2'b00, 1, 32'h0,        2, 0, 32'h00000080, 0, 0, 0, 32'h0,        11'd0);
    op_val = 32'h11223344;
    txn(0, 16'h7001, 1, 2'b00, 0, 32'hFFFFFFAB, 2, 0, 32'h0,        0, 0, 1, 32'h1122AB44, 11'd0);
    txn(1, 16'h703C, 1, 2'b10, 0, 32'h12345678, 2, 0, 32'h0,        0, 0, 1, 32'h12345678, 11'd0);
    txn(0, 16'h4000, 0, 2'b10, 0, 32'h0,        1, 1, 32'h0,        0, 0, 0, 32'h0,        11'd0);
    txn(1, 16'h2001, 0, 2'b01, 0, 32'h0,        1, 1, 32'h0,        0, 0, 0, 32'h0,        11'd0);
    txn(0, 16'h2000, 0, 2'b11, 0, 32'h0,        1, 1, 32'h0,        0, 0, 0, 32'h0,        11'd0);
    txn(1, 16'h2002, 1, 2'b10, 0, 32'h5A5A5A5A, 1, 1, 32'h0,        0, 0, 0, 32'h0,        11'd0);
    txn(0, 16'h7040, 1, 2'b10, 0, 32'h5A5A5A5A, 1, 1, 32'h0,        0, 0, 0, 32'h0,        11'd0);
    txn(0, 16'h2000, 1, 2'b10, 0, 32'hA0A0A0A0, 2, 0, 32'h0,        0, 1, 0, 32'hA0A0A0A0, 11'd0);
    txn(1, 16'h2008, 1, 2'b10, 0, 32'hB1B1B1B1, 2, 0, 32'h0,        0, 1, 0, 32'hB1B1B1B1, 11'd2);

    // Continuous contention: 4 word loads per requester, grants must alternate.
    cnt[0] = 0; cnt[1] = 0;
    @(posedge clk); #1;
    req_addr[0] = 16'h2000; req_addr[1] = 16'h2008;
    req_we = 2'b00; req_size[0] = 2'b10; req_size[1] = 2'b10; req_uns = 2'b00;
    req_valid = 2'b11;
    exp_id = ptr_model;
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      cyc = 0;
      while (req_ready == 2'b00 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk("c_grant", {30'd0, req_ready}, (exp_id == 1) ? 32'd2 : 32'd1);
      got_id = req_ready[1] ? 1 : 0;
      @(posedge clk); #1;
      cnt[got_id]++;
      if (cnt[got_id] == 4) req_valid[got_id] = 1'b0;
      k = 0;
      @(negedge clk);
      while (rsp_valid == 2'b00 && k < 12) begin
        @(negedge clk);
        k++;
      end
      chk("c_rsp_valid", {30'd0, rsp_valid}, (got_id == 1) ? 32'd2 : 32'd1);
      chk("c_rsp_rdata", rsp_rdata, (got_id == 1) ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
      $display("contend grant=%0d rsp_valid=%b rdata=%h", got_id, rsp_valid, rsp_rdata);
      exp_id = 1 - got_id;
      ptr_model = 1 - got_id;
    end
    chk("c_cnt0", cnt[0], 32'd4);
    chk("c_cnt1", cnt[1], 32'd4);

    // Reset during MEM_CAP of a byte store: the RMW must be abandoned.
    @(posedge clk); #1;
    req_addr[0] = 16'h2004; req_we[0] = 1'b1; req_size[0] = 2'b00;
    req_wdata[0] = 32'h00000099; req_valid[0] = 1'b1;
    @(negedge clk);
    chk("r_accept", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("r_in_cap_en", {31'd0, mem_en}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("r_strobes", {29'd0, mem_en, mem_we, op_we}, 32'd0);
    chk("r_rsp", {29'd0, rsp_valid, rsp_err}, 32'd0);
    chk("r_wdata", mem_wdata, 32'd0);
    n_bad_strobe = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we || rsp_valid != 2'b00) n_bad_strobe++;
    end
    rst_n = 1'b1;
    ptr_model = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we || rsp_valid != 2'b00) n_bad_strobe++;
    end
    chk("r_no_strobe", n_bad_strobe, 32'd0);
    $display("reset-mid-rmw strobes_after_reset=%0d", n_bad_strobe);
    txn(1, 16'h2004, 0, 2'b10, 0, 32'h0,        3, 0, 32'hCAFE3344, 1, 0, 0, 32'h0,        11'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_bus_ctrl.md
# lsu_bus_ctrl

Sequencing controller for the load/store bus. It accepts memory requests from two requesters, arbitrates them round-robin, and decodes each address into the data-memory region (0x2000–0x3FFF), the output-peripheral region (0x7000–0x703F) or unmapped. It then drives a synchronous data memory with 1-cycle read latency, or the combinational-read output-peripheral register bank. Sub-word stores are performed as read-modify-write.

## Interface
- DMEM_AW, 11, data-memory word-address width (2048 words)
- OP_AW, 4, peripheral word-address width (16 words)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  2  request valid, bit n = requester n
- o_req_ready  out  2  request accepted this cycle, one-hot or zero
- i_req_addr  in  2x16  byte address
- i_req_we  in  2  1 = store
- i_req_size  in  2x2  00 byte, 01 half, 10 word, 11 illegal
- i_req_unsigned  in  2  zero-extend loads
- i_req_wdata  in  2x32  store data, right-aligned
- o_rsp_valid  out  2  one-cycle response pulse to requester n
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors
- o_rsp_err  out  1  qualifies o_rsp_valid
- o_mem_en, o_mem_we  out  1  memory enable / write
- o_mem_addr  out  DMEM_AW  word address = addr[12:2]
- o_mem_wdata  out  32  full word
- i_mem_rdata  in  32  valid the cycle after o_mem_en with o_mem_we=0
- o_op_we  out  1  peripheral write strobe
- o_op_addr  out  OP_AW  addr[5:2]
- o_op_wdata  out  32  full word
- i_op_rdata  in  32  combinational read of o_op_addr

## Operation
- States: IDLE, MEM_RD, MEM_CAP, MEM_WR, OP_ACC, RESP.
- IDLE: when any valid is high, grant the pointer-preferred requester if valid, otherwise the other one. Pulse o_req_ready for the granted requester. Latch id, addr, we, size, unsigned and wdata. Toggle the pointer to the non-granted index.
- Decode on the latched address:
  - addr[15:13]=001 → DMEM
  - addr[15:6]=0x1C0 → OP
  - anything else → error
- Error cases: unmapped address, size 11, half with addr[0]=1, or word with addr[1:0]≠00. An error goes IDLE→RESP with err=1 and produces no memory or peripheral strobe.
- DMEM transitions:
  - word store: IDLE→MEM_WR
  - load or sub-word store: IDLE→MEM_RD→MEM_CAP (capture i_mem_rdata)
  - from MEM_CAP: load → RESP; sub-word store → MEM_WR
  - MEM_WR → RESP
- OP: IDLE→OP_ACC→RESP. In OP_ACC a load captures i_op_rdata. A store asserts o_op_we for exactly one cycle; a sub-word store merges into i_op_rdata in that same cycle.
- Merge: byte lane = addr[1:0], half lane = addr[1]. Untouched lanes keep the read value.
- Load extract: shift the selected lane to bit 0, then sign-extend unless unsigned.
- RESP: o_rsp_valid[id]=1 for one cycle, then return to IDLE. There is no response backpressure.
- Strobes are Moore outputs of the state:
  - o_mem_en: MEM_RD, MEM_WR
  - o_mem_we: MEM_WR
  - o_op_we: OP_ACC with store
- One transaction is in flight at a time. o_req_ready is only ever asserted in IDLE.

## Timing
- Acceptance in cycle T. Response pulse at:
  - DMEM load: T+3
  - DMEM word store: T+2
  - DMEM sub-word store: T+4
  - OP access: T+2
  - error: T+1
- Requesters hold valid and payload until ready; after acceptance, payload changes are ignored.
- Simultaneous valids: the pointer decides. Under continuous contention the requesters alternate grants.
- A requester may re-request in its own response cycle. The earliest re-acceptance is the cycle after RESP.
- Reset values:
  - state IDLE; pointer = requester 0
  - every output 0: ready, rsp_valid, rsp_rdata, err, all strobes, addresses, wdata
- Reset asserted mid-transaction: all strobes drop asynchronously, the transaction is dropped with no response, and a partially completed RMW is never written.

## Structure
- Package lsu_bus_pkg holds:
  - size_e and state_e enums
  - region constants (DMEM base/mask, OP base/mask)
  - decode, merge and extract functions
- Sub-module lsu_rr_arb2 is a 2-way round-robin arbiter. It takes valid[1:0] and an enable, and outputs a one-hot grant plus the pointer register.

## Test plan
- Req0 word store 0x2004 ← 0xDEADBEEF, then load word 0x2004 → o_mem_addr=1; rsp at T+2 then T+3 with rdata 0xDEADBEEF, err=0.
- Byte store 0x2006 ← 0x55 with memory word 0x11223344 → one MEM_RD, one MEM_WR with wdata 0x11553344; rsp at T+4.
- Signed byte load 0x7003 with i_op_rdata=0x80000000 → rdata 0xFFFFFF80; unsigned → 0x00000080; o_op_we stays 0.
- Both requesters valid continuously, 4 word loads each → grants alternate 0,1,0,1…; each rsp_valid goes only to the owning requester.
- Load 0x4000, half 0x2001, and size 11 → rsp at T+1, err=1, rdata 0, no mem/op strobe.
- Assert i_rst_n low during MEM_CAP of a sub-word store → o_mem_we never pulses, no rsp, outputs 0; after release a new request is accepted normally.
